// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// tagging, 2-entry instruction FIFO toward decode, and redirect flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_vld,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_inst_rdy,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [1:0]  outst;
    logic [1:0]  drop;
    logic [1:0]  cnt;

    logic [31:0] tag_q [2];
    logic        tag_wp;
    logic        tag_rp;

    logic [31:0] fq_pc   [2];
    logic [31:0] fq_inst [2];
    logic        fq_wp;
    logic        fq_rp;

    logic        run;
    logic        grant;
    logic        rsp;
    logic        flush;
    logic        push;
    logic        pop;
    logic [2:0]  credit_used;
    logic [1:0]  outst_nxt;
    logic        unused_ok;

    assign unused_ok = ^i_redirect_pc[1:0];

    // Outstanding requests include those whose responses will be dropped,
    // so the FIFO always has room for every response still in flight.
    assign run         = (state == RUN);
    assign credit_used = {1'b0, outst} + {1'b0, cnt};
    assign o_imem_req  = run & ~i_redirect & (credit_used < 3'd2);
    assign o_imem_addr = fetch_pc;

    assign grant     = o_imem_req & i_imem_gnt;
    assign rsp       = i_imem_rvalid & (outst != 2'd0);
    assign flush     = run & i_redirect;
    assign push      = rsp & ~flush & (drop == 2'd0);
    assign pop       = o_inst_vld & i_inst_rdy & ~flush;
    assign outst_nxt = outst + {1'b0, grant} - {1'b0, rsp};

    assign o_inst_vld = (cnt != 2'd0);
    assign o_inst     = fq_inst[fq_rp];
    assign o_pc       = fq_pc[fq_rp];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= BOOT;
            fetch_pc   <= RESET_PC;
            outst      <= 2'd0;
            drop       <= 2'd0;
            cnt        <= 2'd0;
            tag_q[0]   <= RESET_PC;
            tag_q[1]   <= RESET_PC;
            tag_wp     <= 1'b0;
            tag_rp     <= 1'b0;
            fq_pc[0]   <= RESET_PC;
            fq_pc[1]   <= RESET_PC;
            fq_inst[0] <= 32'h0;
            fq_inst[1] <= 32'h0;
            fq_wp      <= 1'b0;
            fq_rp      <= 1'b0;
        end else begin
            state <= RUN;
            outst <= outst_nxt;

            if (grant) begin
                tag_q[tag_wp] <= fetch_pc;
                tag_wp        <= ~tag_wp;
            end
            if (rsp) begin
                tag_rp <= ~tag_rp;
            end

            if (flush) begin
                drop <= outst_nxt;
            end else if (rsp && drop != 2'd0) begin
                drop <= drop - 2'd1;
            end

            // Redirect in BOOT still retargets the first fetch.
            if (i_redirect) begin
                fetch_pc <= {i_redirect_pc[31:2], 2'b00};
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (flush) begin
                cnt   <= 2'd0;
                fq_wp <= 1'b0;
                fq_rp <= 1'b0;
            end else begin
                if (push) begin
                    fq_pc[fq_wp]   <= tag_q[tag_rp];
                    fq_inst[fq_wp] <= i_imem_rdata;
                    fq_wp          <= ~fq_wp;
                end
                if (pop) begin
                    fq_rp <= ~fq_rp;
                end
                cnt <= cnt + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory responder.
module tb_fetch_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_inst_vld;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_inst_rdy;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    int checks = 0;
    int errors = 0;
    int gcount = 0;
    bit rsp_en = 1'b1;
    logic [31:0] q [$];

    localparam logic [31:0] K = 32'hA000_0000;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_gnt   (i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid),
        .i_imem_rdata (i_imem_rdata),
        .o_inst_vld   (o_inst_vld),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .i_inst_rdy   (i_inst_rdy),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the responder answers each grant in the following cycle.
    task automatic cyc();
        logic        granted;
        logic [31:0] a;
        @(negedge i_clk);
        granted = o_imem_req && i_imem_gnt;
        a       = o_imem_addr;
        @(posedge i_clk);
        #2;
        if (granted) begin
            q.push_back(a);
            gcount++;
        end
        if (rsp_en && q.size() > 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = q.pop_front() ^ K;
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = 32'h0;
        end
        #1;
    endtask

    task automatic wait_vld(input string tag, input int n);
        int k;
        k = 0;
        while (!o_inst_vld && k < n) begin
            cyc();
            k++;
        end
        chk(tag, {31'h0, o_inst_vld}, 32'h1);
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_imem_gnt    = 1'b1;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        i_inst_rdy    = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        #1;
        chk("rst_req",  {31'h0, o_imem_req}, 32'h0);
        chk("rst_addr", o_imem_addr, 32'h0);
        chk("rst_vld",  {31'h0, o_inst_vld}, 32'h0);
        chk("rst_inst", o_inst, 32'h0);
        chk("rst_pc",   o_pc, 32'h0);
        cyc();
        cyc();
        i_rst_n = 1'b1;
        #1;
        chk("boot_req", {31'h0, o_imem_req}, 32'h0);
        cyc();
        chk("first_req",  {31'h0, o_imem_req}, 32'h1);
        chk("first_addr", o_imem_addr, 32'h0);

        for (int k = 0; k < 4; k++) begin
            wait_vld("seq_vld", 10);
            chk("seq_pc",   o_pc, 32'(4 * k));
            chk("seq_inst", o_inst, 32'(4 * k) ^ K);
            cyc();
        end

        // Decoder stalls: FIFO fills, requests stop.
        i_inst_rdy = 1'b0;
        gcount = 0;
        for (int k = 0; k < 6; k++) cyc();
        chk("stall_vld",  {31'h0, o_inst_vld}, 32'h1);
        chk("stall_pc",   o_pc, 32'h10);
        chk("stall_inst", o_inst, 32'h10 ^ K);
        chk("stall_req",  {31'h0, o_imem_req}, 32'h0);
        chk("stall_gnts", {31'h0, gcount <= 2}, 32'h1);
        cyc();
        chk("stall_pc2",  o_pc, 32'h10);

        // Grant withheld: address and request must hold.
        i_imem_gnt = 1'b0;
        i_inst_rdy = 1'b1;
        #1;
        chk("drain_pc0", o_pc, 32'h10);
        cyc();
        chk("drain_pc1", o_pc, 32'h14);
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("hold_req",  {31'h0, o_imem_req}, 32'h1);
            chk("hold_addr", o_imem_addr, 32'h18);
            cyc();
        end
        i_imem_gnt = 1'b1;
        rsp_en     = 1'b0;
        #1;
        chk("gnt_addr0", o_imem_addr, 32'h18);
        cyc();
        chk("gnt_addr1", o_imem_addr, 32'h1C);
        chk("gnt_req1",  {31'h0, o_imem_req}, 32'h1);
        cyc();
        chk("credit_req", {31'h0, o_imem_req}, 32'h0);

        // Redirect with two requests in flight.
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        rsp_en        = 1'b1;
        #1;
        chk("redir_req", {31'h0, o_imem_req}, 32'h0);
        cyc();
        i_redirect = 1'b0;
        #1;
        chk("redir_addr", o_imem_addr, 32'h100);
        chk("redir_vld",  {31'h0, o_inst_vld}, 32'h0);
        wait_vld("redir_wait", 10);
        chk("redir_pc",   o_pc, 32'h100);
        chk("redir_inst", o_inst, 32'h100 ^ K);
        cyc();

        // Unaligned target is forced to a word boundary.
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h203;
        #1;
        chk("align_req", {31'h0, o_imem_req}, 32'h0);
        cyc();
        i_redirect = 1'b0;
        #1;
        chk("align_addr", o_imem_addr, 32'h200);
        wait_vld("align_wait", 10);
        chk("align_pc",   o_pc, 32'h200);
        chk("align_inst", o_inst, 32'h200 ^ K);
        cyc();

        // Fetch PC wraps from the top of the address space.
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        #1;
        cyc();
        i_redirect = 1'b0;
        #1;
        chk("wrap_addr", o_imem_addr, 32'hFFFF_FFFC);
        wait_vld("wrap_wait0", 10);
        chk("wrap_pc0",   o_pc, 32'hFFFF_FFFC);
        chk("wrap_inst0", o_inst, 32'hFFFF_FFFC ^ K);
        cyc();
        wait_vld("wrap_wait1", 10);
        chk("wrap_pc1",   o_pc, 32'h0);
        chk("wrap_inst1", o_inst, 32'h0 ^ K);

        // Fill FIFO, then reset asynchronously mid-cycle.
        i_inst_rdy = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        chk("full_vld", {31'h0, o_inst_vld}, 32'h1);
        chk("full_pc",  o_pc, 32'h0);
        i_rst_n = 1'b0;
        rsp_en  = 1'b0;
        #1;
        chk("arst_req",  {31'h0, o_imem_req}, 32'h0);
        chk("arst_addr", o_imem_addr, 32'h0);
        chk("arst_vld",  {31'h0, o_inst_vld}, 32'h0);
        chk("arst_inst", o_inst, 32'h0);
        chk("arst_pc",   o_pc, 32'h0);
        cyc();
        cyc();
        q.delete();
        i_rst_n    = 1'b1;
        i_imem_gnt = 1'b0;
        i_inst_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = 32'h1234_5678;
            #1;
            chk("stale_vld", {31'h0, o_inst_vld}, 32'h0);
            cyc();
        end
        i_imem_rvalid = 1'b0;
        i_imem_gnt    = 1'b1;
        rsp_en        = 1'b1;
        #1;
        chk("post_req",  {31'h0, o_imem_req}, 32'h1);
        chk("post_addr", o_imem_addr, 32'h0);
        wait_vld("post_wait", 10);
        chk("post_pc",   o_pc, 32'h0);
        chk("post_inst", o_inst, 32'h0 ^ K);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
